// File: rtl/prefix_token_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : prefix_token_tx                                              |
// | Description : Captures a 19-token infix expression (10 operands, 9 binary  |
// |               operators), converts it to prefix order with a reverse-scan  |
// |               shunting-yard operator stack, and streams the prefix tokens  |
// |               to the evaluator as 19 consecutive valid cycles.             |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               in_valid/in_data  - infix token stream, one per cycle        |
// |               busy              - high outside IDLE, in_valid ignored      |
// |               out_valid/out_data- prefix token stream                      |
// |               out_opt           - evaluator mode bit, always 0 (prefix)    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module prefix_token_tx #(
  parameter int N_TOK = 19,
  parameter int TOK_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [TOK_W-1:0] in_data,
  output logic             busy,
  output logic             out_valid,
  output logic             out_opt,
  output logic [TOK_W-1:0] out_data
);

  localparam int C_N_OPS    = (N_TOK - 1) / 2;     // also the stack depth
  localparam int C_CONV_CYC = N_TOK + C_N_OPS;     // scans + pops
  localparam int C_IW       = $clog2(N_TOK + 1);
  localparam int C_SW       = $clog2(C_N_OPS + 1);
  localparam int C_CW       = $clog2(C_CONV_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CONV = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [TOK_W-1:0] r_in_buf  [N_TOK];
  logic [TOK_W-1:0] r_out_buf [N_TOK];
  logic [TOK_W-2:0] r_stk     [C_N_OPS];
  logic [C_IW-1:0]  r_ld_cnt;    // tokens captured so far
  logic [C_IW-1:0]  r_scan_rem;  // tokens still to scan; next is in_buf[rem-1]
  logic [C_IW-1:0]  r_wr_rem;    // out_buf slots still free; next is [rem-1]
  logic [C_SW-1:0]  r_sp;        // stack occupancy
  logic [C_CW-1:0]  r_cyc;       // conversion cycles elapsed
  logic [C_IW-1:0]  r_out_idx;

  function automatic logic f_is_hi(input logic [TOK_W-2:0] code);
    return (code == (TOK_W-1)'(2)) || (code == (TOK_W-1)'(3));
  endfunction

  // Conversion datapath decode
  logic [C_IW-1:0]  w_scan_idx, w_wr_idx;
  logic [TOK_W-1:0] w_tok, w_wr_tok;
  logic [TOK_W-2:0] w_top;
  logic             w_scan_done, w_stk_empty, w_stk_full, w_conv_end;
  logic             w_do_pop, w_do_push, w_do_opnd, w_wr_en;

  assign w_scan_idx  = r_scan_rem - 1'b1;
  assign w_wr_idx    = r_wr_rem - 1'b1;
  assign w_scan_done = (r_scan_rem == '0);
  assign w_stk_empty = (r_sp == '0);
  assign w_stk_full  = (r_sp == C_SW'(C_N_OPS));
  assign w_conv_end  = (r_cyc == C_CW'(C_CONV_CYC));
  assign w_tok       = w_scan_done ? '0 : r_in_buf[w_scan_idx];
  assign w_top       = w_stk_empty ? '0 : r_stk[r_sp - 1'b1];

  // Pop when draining after the scan, or when the stack top binds strictly
  // tighter than the incoming operator; equal precedence stays stacked,
  // which yields left-associativity for a right-to-left scan.
  assign w_do_pop  = (r_state == S_CONV) && !w_conv_end && !w_stk_empty &&
                     (w_scan_done ||
                      (w_tok[TOK_W-1] && f_is_hi(w_top) && !f_is_hi(w_tok[TOK_W-2:0])));
  assign w_do_push = (r_state == S_CONV) && !w_conv_end && !w_scan_done &&
                     w_tok[TOK_W-1] && !w_do_pop;
  assign w_do_opnd = (r_state == S_CONV) && !w_conv_end && !w_scan_done &&
                     !w_tok[TOK_W-1];
  // Malformed input can ask for more writes than slots; extra writes drop.
  assign w_wr_en   = (w_do_pop || w_do_opnd) && (r_wr_rem != '0);
  assign w_wr_tok  = w_do_pop ? {1'b1, w_top} : w_tok;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and next output values
  logic             w_busy_nxt, w_ov_nxt;
  logic [TOK_W-1:0] w_od_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_ov_nxt    = 1'b0;
    w_od_nxt    = '0;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (!in_valid)                            w_state_nxt = S_IDLE;
        else if (r_ld_cnt == C_IW'(N_TOK - 1))    w_state_nxt = S_CONV;
      end
      S_CONV: if (w_conv_end) w_state_nxt = S_OUT;
      S_OUT: begin
        if (r_out_idx == C_IW'(N_TOK)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_ov_nxt = 1'b1;
          w_od_nxt = r_out_buf[r_out_idx];
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Buffers, stack and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TOK; i++) begin
        r_in_buf[i]  <= '0;
        r_out_buf[i] <= '0;
      end
      for (int i = 0; i < C_N_OPS; i++) r_stk[i] <= '0;
      r_ld_cnt   <= '0;
      r_scan_rem <= '0;
      r_wr_rem   <= '0;
      r_sp       <= '0;
      r_cyc      <= '0;
      r_out_idx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_buf[0] <= in_data;
            r_ld_cnt    <= C_IW'(1);
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            r_in_buf[r_ld_cnt] <= in_data;
            r_ld_cnt           <= r_ld_cnt + 1'b1;
          end
          // Arm the converter; only meaningful when LOAD completes.
          r_scan_rem <= C_IW'(N_TOK);
          r_wr_rem   <= C_IW'(N_TOK);
          r_sp       <= '0;
          r_cyc      <= '0;
        end
        S_CONV: begin
          if (!w_conv_end) r_cyc <= r_cyc + 1'b1;
          if (w_do_opnd || w_do_push) r_scan_rem <= r_scan_rem - 1'b1;
          if (w_do_push && !w_stk_full) begin
            r_stk[r_sp] <= w_tok[TOK_W-2:0];
            r_sp        <= r_sp + 1'b1;
          end
          if (w_do_pop) r_sp <= r_sp - 1'b1;
          if (w_wr_en) begin
            r_out_buf[w_wr_idx] <= w_wr_tok;
            r_wr_rem            <= r_wr_rem - 1'b1;
          end
          r_out_idx <= '0;
        end
        S_OUT: begin
          if (r_out_idx != C_IW'(N_TOK)) r_out_idx <= r_out_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_opt   <= 1'b0;
      out_data  <= '0;
    end else begin
      busy      <= w_busy_nxt;
      out_valid <= w_ov_nxt;
      out_opt   <= 1'b0;
      out_data  <= w_od_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prefix_token_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_prefix_token_tx                                           |
// | Description : Self-checking bench for prefix_token_tx. Expected prefix     |
// |               streams come from a term-splitting model of left-assoc       |
// |               two-level precedence expressions.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_prefix_token_tx;

  typedef logic [4:0] frame_t [19];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_data = '0;
  logic       busy, out_valid, out_opt;
  logic [4:0] out_data;

  always #5 clk = ~clk;

  prefix_token_tx #(.N_TOK(19), .TOK_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .busy(busy), .out_valid(out_valid), .out_opt(out_opt), .out_data(out_data)
  );

  int         checks = 0;
  int         errors = 0;
  logic [5:0] exp_q[$];        // bit5 set = content unspecified
  time        t_last = 0;      // edge that sampled the 19th token
  bit         lat_check = 0;
  bit         prev_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_hi(input logic [4:0] t);
    return t[4] && (t[3:0] == 4'd2 || t[3:0] == 4'd3);
  endfunction

  // Prefix of a left-assoc chain x0 o1 x1 o2 x2 ... is o_k..o1 P(x0) P(x1)...
  // Applied at the low level (terms) and again inside each product term.
  function automatic frame_t to_prefix(input frame_t inf);
    frame_t res;
    int n = 0;
    int s = 0;
    for (int j = 17; j >= 1; j -= 2)
      if (!is_hi(inf[j])) begin res[n] = inf[j]; n++; end
    for (int j = 1; j <= 19; j += 2) begin
      bit brk;
      brk = (j == 19);
      if (!brk) brk = !is_hi(inf[j]);
      if (brk) begin
        for (int k = j - 2; k > s; k -= 2) begin res[n] = inf[k]; n++; end
        for (int k = s; k < j; k += 2)     begin res[n] = inf[k]; n++; end
        s = j + 1;
      end
    end
    return res;
  endfunction

  // Compare process: every cycle
  always @(negedge clk) begin
    logic [5:0] e;
    chk("out_opt", out_opt, 0);
    if (out_valid) begin
      chk("busy_in_out", busy, 1);
      if (!prev_valid && lat_check)
        chk("latency", int'(($time - 5 - t_last) / 10), 30);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got out_valid=1 data=%0h, expected out_valid=0", out_data);
      end else begin
        e = exp_q.pop_front();
        if (!e[5]) chk("out_data", out_data, e[4:0]);
      end
    end else begin
      chk("idle_data", out_data, 0);
      if (prev_valid && exp_q.size() != 0) begin
        checks++; errors++;
        $display("FAIL early_drop: got out_valid=0 with %0d tokens pending, expected 1", exp_q.size());
      end
    end
    prev_valid = out_valid;
  end

  task automatic send(input frame_t f, input bit dont_care);
    frame_t p;
    p = to_prefix(f);
    for (int i = 0; i < 19; i++) exp_q.push_back(dont_care ? 6'h20 : {1'b0, p[i]});
    lat_check = !dont_care;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = f[i];
    end
    @(posedge clk);
    t_last = $time;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    frame_t f1, f2, f3, f4, fm, r;
    frame_t lit2;
    logic [4:0] ops4 [9];
    int n;

    lit2 = '{5'h10, 5'h10, 5'h10, 5'h10, 5'h12, 5'h01, 5'h02, 5'h12, 5'h03, 5'h04,
             5'h12, 5'h05, 5'h06, 5'h12, 5'h07, 5'h08, 5'h12, 5'h09, 5'h0A};
    ops4 = '{5'h13, 5'h11, 5'h12, 5'h17, 5'h13, 5'h12, 5'h10, 5'h1F, 5'h12};
    for (int i = 0; i < 10; i++) begin
      f1[2*i] = 5'(i + 1);
      f2[2*i] = 5'(i + 1);
      f3[2*i] = (i == 0) ? 5'h09 : 5'h01;
      f4[2*i] = 5'((i * 7 + 3) % 16);
    end
    for (int m = 0; m < 9; m++) begin
      f1[2*m+1] = 5'h10;
      f2[2*m+1] = (m % 2 == 0) ? 5'h12 : 5'h10;
      f3[2*m+1] = 5'h11;
      f4[2*m+1] = ops4[m];
    end
    for (int i = 0; i < 19; i++) fm[i] = (i < 12) ? 5'h12 : 5'h10;

    // Pin the model against hand-derived streams
    r = to_prefix(f2);
    for (int i = 0; i < 19; i++) chk("model_f2", r[i], lit2[i]);
    r = to_prefix(f3);
    chk("model_f3_op", r[8], 5'h11);
    chk("model_f3_first", r[9], 5'h09);
    chk("model_f3_last", r[18], 5'h01);
    r = to_prefix(f1);
    chk("model_f1_op", r[0], 5'h10);
    chk("model_f1_opnd", r[9], 5'h01);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_opt", out_opt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(f1, 0); wait_done("f1");
    send(f2, 0); wait_done("f2");
    send(f3, 0); wait_done("f3");
    send(f4, 0); wait_done("f4");

    // Aborted frame: 7 tokens then in_valid drops
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = f4[i];
      if (i == 6) chk("abort_busy_load", busy, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    chk("abort_busy_fall", busy, 0);
    send(f2, 0); wait_done("after_abort");

    // Malformed: non-alternating operators; content unspecified, must finish
    send(fm, 1); wait_done("malformed");

    // Reset during OUT at token 5
    send(f4, 0);
    n = 0;
    for (int k = 0; k < 100 && n < 5; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("reached_tok5", n, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(f1, 0); wait_done("post_reset");

    // New frame presented while OUT is running must be ignored
    send(f3, 0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ovl_out_seen", out_valid, 1);
    for (int i = 0; i < 19; i++) begin
      in_valid = 1'b1;
      in_data  = f2[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
    wait_done("overlap");
    repeat (60) @(negedge clk);
    chk("ovl_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
